// File: rtl/tbec_full_mem.sv
// tbec_full_mem: 256x16 memory stored as 22-bit Hamming SEC-DED codewords.
// Reads are decoded and corrected every cycle into registered outputs; storage is never scrubbed.
module tbec_full_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              tbec_clk,
    input  logic              tbec_rst_n,
    input  logic [ADDR_W-1:0] tbec_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_we,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        out_error_code
);
    localparam int CW = 22;

    logic [CW-1:0]     mem [2**ADDR_W];
    logic [CW-1:0]     enc, rd, fixed;
    logic [4:0]        s, ds;
    logic              pe, single;
    logic [1:0]        code_next;
    logic [DATA_W-1:0] data_next;

    function automatic logic [CW-1:0] place(input logic [DATA_W-1:0] d);
        return {d[15:11], 1'b0, d[10:4], 1'b0, d[3:1], 1'b0, d[0], 3'b000};
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] w);
        return {w[21:17], w[15:9], w[7:5], w[3]};
    endfunction

    function automatic logic [4:0] synd(input logic [CW-1:0] w);
        logic [4:0] r;
        r = '0;
        for (int j = 1; j < CW; j++) r ^= w[j] ? 5'(j) : 5'd0;
        return r;
    endfunction

    // The syndrome of the data-only word is exactly the set of check bits to store.
    always_comb begin
        enc = place(data_in);
        ds = synd(enc);
        enc[1] = ds[0];
        enc[2] = ds[1];
        enc[4] = ds[2];
        enc[8] = ds[3];
        enc[16] = ds[4];
        enc[0] = ^enc[CW-1:1];
    end

    always_comb begin
        rd = mem[tbec_addr];
        s = synd(rd);
        pe = ^rd;
        single = pe && s != 5'd0 && s < 5'(CW);
        fixed = rd ^ (single ? (CW'(1) << s) : '0);
        code_next = pe ? (s < 5'(CW) ? 2'b01 : 2'b11) : (s == 5'd0 ? 2'b00 : 2'b10);
        data_next = extract(fixed);
    end

    always_ff @(posedge tbec_clk) begin
        if (tbec_rst_n && mem_we) mem[tbec_addr] <= enc;
    end

    always_ff @(posedge tbec_clk or negedge tbec_rst_n) begin
        if (!tbec_rst_n) begin
            data_out <= '0;
            out_error_code <= 2'b00;
        end else begin
            data_out <= data_next;
            out_error_code <= code_next;
        end
    end
endmodule

// File: tb/tb_tbec_full_mem.sv
// tb_tbec_full_mem: randomized and directed checks of tbec_full_mem against a codeword-level model.
module tb_tbec_full_mem;
    logic        clk, rst_n, we;
    logic [7:0]  addr;
    logic [15:0] din, dout;
    logic [1:0]  code;
    logic [21:0] model_mem [256];
    int          n_checks = 0, n_fail = 0;

    tbec_full_mem dut (
        .tbec_clk(clk), .tbec_rst_n(rst_n), .tbec_addr(addr), .data_in(din),
        .mem_we(we), .data_out(dout), .out_error_code(code)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "timeout");
    end

    function automatic bit is_pow2(input int j);
        return (j & (j - 1)) == 0;
    endfunction

    function automatic logic [21:0] enc(input logic [15:0] d);
        logic [21:0] w;
        int k;
        w = '0;
        k = 0;
        for (int j = 1; j < 22; j++) if (!is_pow2(j)) begin w[j] = d[k]; k++; end
        for (int b = 0; b < 5; b++) begin
            logic p;
            p = 0;
            for (int j = 1; j < 22; j++) if (j[b] && j != (1 << b)) p ^= w[j];
            w[1 << b] = p;
        end
        w[0] = ^w[21:1];
        return w;
    endfunction

    function automatic void dec(input logic [21:0] w, output logic [15:0] d, output logic [1:0] c);
        int s, k;
        logic [21:0] v;
        logic pe;
        s = 0;
        k = 0;
        v = w;
        pe = ^w;
        for (int j = 1; j < 22; j++) if (w[j]) s ^= j;
        if (s == 0) c = pe ? 2'b01 : 2'b00;
        else if (!pe) c = 2'b10;
        else if (s <= 21) begin c = 2'b01; v[s] = ~v[s]; end
        else c = 2'b11;
        d = '0;
        for (int j = 1; j < 22; j++) if (!is_pow2(j)) begin d[k] = v[j]; k++; end
    endfunction

    task automatic step(input logic [7:0] a, input logic [15:0] d, input logic w,
                        output logic [15:0] ed, output logic [1:0] ec);
        addr = a;
        din = d;
        we = w;
        @(posedge clk);
        dec(model_mem[a], ed, ec);
        if (w && rst_n) model_mem[a] = enc(d);
        @(negedge clk);
    endtask

    task automatic flip(input logic [7:0] a, input int pos);
        dut.mem[a] = dut.mem[a] ^ (22'd1 << pos);
        model_mem[a] = model_mem[a] ^ (22'd1 << pos);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dout !== 16'h0000 || code !== 2'b00) begin
            n_fail++;
            $display("FAIL reset: data_out=%h code=%b, required 0000/00", dout, code);
        end
        rst_n = 1;
    endtask

    task automatic test_write_hold;
        logic [15:0] ed;
        logic [1:0]  ec;
        step(8'h01, 16'hE1F0, 1, ed, ec);
        n_checks++;
        if (dout !== ed || code !== ec) begin
            n_fail++;
            $display("FAIL write_cycle: data_out=%h code=%b, required %h/%b", dout, code, ed, ec);
        end
        for (int i = 0; i < 10; i++) begin
            step(8'h01, 16'h0000, 0, ed, ec);
            n_checks++;
            if (dout !== 16'hE1F0 || code !== 2'b00 || ed !== 16'hE1F0) begin
                n_fail++;
                $display("FAIL hold[%0d]: data_out=%h code=%b, required E1F0/00", i, dout, code);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ed;
        logic [1:0]  ec;
        logic [7:0]  ra [3] = '{8'h01, 8'h02, 8'h07};
        logic [15:0] rd [3] = '{16'hE1F0, 16'hBBCC, 16'hFFA0};
        step(8'h02, 16'hBBCC, 1, ed, ec);
        step(8'h07, 16'hFFA0, 1, ed, ec);
        for (int i = 0; i < 3; i++) begin
            step(ra[i], 16'h0000, 0, ed, ec);
            n_checks++;
            if (dout !== rd[i] || code !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b_read @%h: data_out=%h code=%b, required %h/00", ra[i], dout, code, rd[i]);
            end
        end
    endtask

    task automatic test_single_error;
        logic [15:0] ed, d;
        logic [1:0]  ec;
        logic [7:0]  a;
        int          p;
        flip(8'h01, 9);
        step(8'h01, 16'h0000, 0, ed, ec);
        n_checks++;
        if (dout !== 16'hE1F0 || code !== 2'b01) begin
            n_fail++;
            $display("FAIL single_pos9: data_out=%h code=%b, required E1F0/01", dout, code);
        end
        flip(8'h01, 9);
        flip(8'h01, 0);
        step(8'h01, 16'h0000, 0, ed, ec);
        n_checks++;
        if (dout !== 16'hE1F0 || code !== 2'b01) begin
            n_fail++;
            $display("FAIL single_pos0: data_out=%h code=%b, required E1F0/01", dout, code);
        end
        flip(8'h01, 0);
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(16, 255));
            d = 16'($urandom);
            p = (i < 22) ? i : int'($urandom_range(0, 21));
            step(a, d, 1, ed, ec);
            flip(a, p);
            step(a, 16'h0000, 0, ed, ec);
            n_checks++;
            if (dout !== ed || code !== ec || dout !== d) begin
                n_fail++;
                $display("FAIL single_rand pos=%0d: data_out=%h code=%b, required %h/%b", p, dout, code, ed, ec);
            end
        end
    endtask

    task automatic test_double_error;
        logic [15:0] ed;
        logic [1:0]  ec;
        logic [7:0]  a;
        int          p, q;
        flip(8'h02, 3);
        flip(8'h02, 5);
        step(8'h02, 16'h0000, 0, ed, ec);
        n_checks++;
        if (dout !== 16'hBBCF || code !== 2'b10) begin
            n_fail++;
            $display("FAIL double_3_5: data_out=%h code=%b, required BBCF/10", dout, code);
        end
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom_range(16, 255));
            p = int'($urandom_range(0, 21));
            q = (p + 1 + int'($urandom_range(0, 20))) % 22;
            step(a, 16'($urandom), 1, ed, ec);
            flip(a, p);
            flip(a, q);
            step(a, 16'h0000, 0, ed, ec);
            n_checks++;
            if (dout !== ed || code !== ec || code !== 2'b10) begin
                n_fail++;
                $display("FAIL double_rand %0d,%0d: data_out=%h code=%b, required %h/10", p, q, dout, code, ed);
            end
        end
    endtask

    task automatic test_invalid;
        logic [15:0] ed;
        logic [1:0]  ec;
        step(8'h09, 16'h5A3C, 1, ed, ec);
        flip(8'h09, 16);
        flip(8'h09, 8);
        flip(8'h09, 1);
        step(8'h09, 16'h0000, 0, ed, ec);
        n_checks++;
        if (dout !== 16'h5A3C || code !== 2'b11 || ec !== 2'b11) begin
            n_fail++;
            $display("FAIL invalid_syndrome: data_out=%h code=%b, required 5A3C/11", dout, code);
        end
    endtask

    task automatic test_same_cycle;
        logic [15:0] ed;
        logic [1:0]  ec;
        step(8'h01, 16'h1234, 1, ed, ec);
        n_checks++;
        if (dout !== 16'hE1F0 || code !== 2'b00) begin
            n_fail++;
            $display("FAIL same_cycle_old: data_out=%h code=%b, required E1F0/00", dout, code);
        end
        step(8'h01, 16'h0000, 0, ed, ec);
        n_checks++;
        if (dout !== 16'h1234 || code !== 2'b00) begin
            n_fail++;
            $display("FAIL same_cycle_new: data_out=%h code=%b, required 1234/00", dout, code);
        end
    endtask

    task automatic test_random;
        logic [15:0] ed;
        logic [1:0]  ec;
        for (int i = 0; i < 200; i++) begin
            step(8'($urandom_range(0, 31)), 16'($urandom), 1'($urandom), ed, ec);
            n_checks++;
            if (dout !== ed || code !== ec) begin
                n_fail++;
                $display("FAIL random[%0d]: data_out=%h code=%b, required %h/%b", i, dout, code, ed, ec);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] ed;
        logic [1:0]  ec;
        step(8'h01, 16'h1234, 1, ed, ec);
        step(8'h01, 16'h0000, 0, ed, ec);
        n_checks++;
        if (dout !== 16'h1234 || code !== 2'b00) begin
            n_fail++;
            $display("FAIL pre_reset_read: data_out=%h code=%b, required 1234/00", dout, code);
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (dout !== 16'h0000 || code !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: data_out=%h code=%b, required 0000/00", dout, code);
        end
        addr = 8'h01;
        din = 16'h5555;
        we = 1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dout !== 16'h0000 || code !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: data_out=%h code=%b, required 0000/00", dout, code);
        end
        rst_n = 1;
        step(8'h01, 16'h0000, 0, ed, ec);
        n_checks++;
        if (dout !== 16'h1234 || code !== 2'b00 || ed !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_in_reset: data_out=%h code=%b, required 1234/00", dout, code);
        end
    endtask

    initial begin
        rst_n = 0;
        we = 0;
        addr = '0;
        din = '0;
        for (int i = 0; i < 256; i++) begin
            dut.mem[i] = '0;
            model_mem[i] = '0;
        end
        test_reset;
        test_write_hold;
        test_back_to_back;
        test_single_error;
        test_double_error;
        test_invalid;
        test_same_cycle;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tbec_full_mem.md
Name: tbec_full_mem

Overview:
- Single-port 256 x 16 data memory protected by a Hamming SEC-DED code (16 data bits + 6 check bits = 22-bit stored codeword).
- The encoder runs on every write.
- Every cycle, the decoder checks and corrects the word at the current address.
- The corrected data and a 2-bit error status are registered to the outputs.
- The block sits between a simple address/data master and on-chip storage, providing single-error correction and double-error detection.

Parameters:
- ADDR_W, 8: address width; depth is 2**ADDR_W words.
- DATA_W, 16: data width. The codeword layout below is fixed for 16 bits; other values are unsupported.

Ports:
- tbec_clk  input  1  clock; all state updates on the rising edge.
- tbec_rst_n  input  1  reset, asynchronous, active-low.
- tbec_addr  input  8  word address, shared by read and write.
- data_in  input  16  write data.
- mem_we  input  1  write enable; when 1, write data_in at tbec_addr on the rising edge.
- data_out  output  16  registered, corrected read data.
- out_error_code  output  2  registered status for data_out.

Behaviour:
- Storage: array named mem, 256 entries x 22 bits. Bit i of an entry is code position i.
  - Position 0: overall parity.
  - Positions 1, 2, 4, 8, 16: Hamming check bits p1, p2, p4, p8, p16.
  - Data bits d0..d15 occupy positions 3, 5, 6, 7, 9..15, 17..21, in ascending order.
- Encode on write:
  - Each pK = XOR of all positions j in 1..21 (excluding K) whose index has bit K set.
  - Position 0 = XOR of positions 1..21, giving even parity over all 22 bits.
- Write: on the rising edge with mem_we=1, mem[tbec_addr] <= encoded data_in. There is no byte masking.
- Mem contents are not affected by reset. The simulation model initialises every entry to 0, which is a valid codeword for data 0.
- Read, every rising edge regardless of mem_we:
  - Read word w = mem[tbec_addr], using the pre-write (read-first) value when writing the same address.
  - Syndrome s[4:0] = XOR of the indices of all set positions 1..21 in w.
  - Parity error pe = XOR of all 22 bits of w.
  - Decode cases, registered into data_out / out_error_code:
    - s=0, pe=0: no error. data_out = data bits of w; code 2'b00.
    - s=0, pe=1: overall parity bit flipped. data_out = data bits; code 2'b01.
    - s in 1..21, pe=1: single error. Flip position s, then extract data; code 2'b01.
    - s!=0, pe=0: double error. data_out = uncorrected data bits; code 2'b10.
    - s in 22..31, pe=1: invalid syndrome, uncorrectable. data_out = uncorrected data bits; code 2'b11.
- Latency:
  - Address to data_out: 1 clock (value captured at the edge, visible after it).
  - Write to readable: data written at edge N appears on data_out after edge N+1 if tbec_addr is held.
- Memory is never scrubbed; correction is applied only to the output.
- Reset: while tbec_rst_n=0, data_out=16'h0000 and out_error_code=2'b00, asynchronously.
  - Writes are ignored while reset is asserted.
  - After release, the first rising edge resumes normal reads.
- Reset mid-operation: an in-progress write at an edge where tbec_rst_n=0 is dropped; stored contents are untouched.
- Address wraps naturally; all 256 addresses are valid, with no out-of-range cases.
- X on tbec_addr or mem_we produces don't-care outputs; the bench must drive known values.

Test Plan:
- Reset, then write 16'hE1F0 to addr 8'h01, deassert mem_we, hold addr 8'h01 for 10 cycles -> data_out=16'hE1F0, out_error_code=2'b00 from the cycle after the write onward.
- Write 16'hBBCC @8'h02 and 16'hFFA0 @8'h07 on consecutive cycles, then read 8'h01, 8'h02, 8'h07 -> E1F0, BBCC, FFA0, each 1 cycle after the address is presented, code 00.
- Backdoor-flip position 9 (d4) of mem[8'h01] holding E1F0 -> data_out=16'hE1F0, code 2'b01. Also flip position 0 only -> E1F0, code 01.
- Backdoor-flip positions 3 and 5 of mem[8'h02] holding BBCC -> code 2'b10; data_out=BBCC with d0 and d1 inverted (16'hBBCF).
- Same-cycle write and read: write 16'h1234 to an address holding 16'hE1F0 -> data_out shows E1F0 that cycle and 1234 the next.
- Assert tbec_rst_n=0 asynchronously mid-read -> outputs go to 0000/00 immediately. A write attempted during reset is absent afterwards, and prior contents are intact.
